flatten_row_collector: RTL and testbench

Collects the 14x14 binary feature map from the upstream pooling stage, one 14-bit row per accepted transfer, into a 196-bit flattened vector. When complete, it presents the vector with out_valid. out_valid drives the en input of final_layer_sequential. The vector is held stable until the final layer reports done, then the collector clears and accepts the next image.

---
 rtl/bnn_pkg.sv | 16 +
 rtl/flatten_row_collector.sv | 88 ++++++++
 tb/tb_flatten_row_collector.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared BNN definitions: image geometry, collector state encoding and the
// flattened feature vector type used by the collector and the final layer.
package bnn_pkg;

    localparam int unsigned IMG_ROWS  = 14;
    localparam int unsigned IMG_COLS  = 14;
    localparam int unsigned FLAT_BITS = IMG_ROWS * IMG_COLS;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } flat_state_t;

    typedef logic [FLAT_BITS-1:0] flat_vec_t;

endpackage

// File: rtl/flatten_row_collector.sv
// Gathers one image of ROWS rows of COLS bits into a flat vector and holds it
// for the final layer until consume_done. Macro FLATTEN_COL_MAJOR_EN selects column-major bit order.
module flatten_row_collector
    import bnn_pkg::*;
#(
    parameter int unsigned ROWS = IMG_ROWS,
    parameter int unsigned COLS = IMG_COLS,
    localparam int unsigned NUM_INPUTS = ROWS * COLS,
    localparam int unsigned CNT_W = $clog2(ROWS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COLS-1:0]       in_row,
    output logic                  out_valid,
    output logic [NUM_INPUTS-1:0] data_out,
    input  logic                  consume_done,
    output logic [CNT_W-1:0]      rows_filled
);

    flat_state_t           state_q, state_d;
    logic [NUM_INPUTS-1:0] data_q, data_d;
    logic [CNT_W-1:0]      rows_q, rows_d;
    int unsigned           row_idx;

    assign row_idx = 32'(rows_q);

    function automatic int unsigned slot_idx(input int unsigned r, input int unsigned c);
`ifdef FLATTEN_COL_MAJOR_EN
        return c * ROWS + r;
`else
        return r * COLS + c;
`endif
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FILL;
            data_q  <= '0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rows_q  <= rows_d;
        end
    end

    // in_ready is 1 throughout FILL, so in_valid alone qualifies an accept there.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rows_d  = rows_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    for (int unsigned c = 0; c < COLS; c++) begin
                        data_d[slot_idx(row_idx, c)] = in_row[c];
                    end
                    rows_d = rows_q + CNT_W'(1);
                    if (row_idx == ROWS - 1) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (consume_done) begin
                    state_d = FILL;
                    data_d  = '0;
                    rows_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
                data_d  = '0;
                rows_d  = '0;
            end
        endcase
    end

    always_comb begin
        in_ready    = (state_q == FILL);
        out_valid   = (state_q == FULL);
        data_out    = data_q;
        rows_filled = rows_q;
    end

endmodule

// File: tb/tb_flatten_row_collector.sv
// Scoreboard bench for flatten_row_collector: stimulus queues each expected
// flattened vector, a monitor compares when out_valid rises and while held.
module tb_flatten_row_collector;
    import bnn_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_row = '0;
    logic        out_valid;
    flat_vec_t   data_out;
    logic        consume_done = 1'b0;
    logic [3:0]  rows_filled;

    int n_checks = 0;
    int n_fail   = 0;

    flat_vec_t   exp_q[$];
    flat_vec_t   held_exp = '0;
    logic        prev_ov = 1'b0;
    logic [13:0] img[14];
    flat_vec_t   exp_v;

    flatten_row_collector dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .out_valid    (out_valid),
        .data_out     (data_out),
        .consume_done (consume_done),
        .rows_filled  (rows_filled)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int unsigned flat_idx(input int unsigned r, input int unsigned c);
`ifdef FLATTEN_COL_MAJOR_EN
        return c * 14 + r;
`else
        return r * 14 + c;
`endif
    endfunction

    function automatic flat_vec_t build(input int n);
        flat_vec_t v = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < 14; c++)
                v[flat_idx(r, c)] = img[r][c];
        return v;
    endfunction

    // Monitor: pop on out_valid rising, then require the vector to stay put.
    always @(negedge clock) begin
        if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                held_exp = exp_q.pop_front();
                check("vector", data_out, held_exp);
            end
        end else if (out_valid === 1'b1) begin
            check("hold_stable", data_out, held_exp);
        end
        prev_ov = out_valid;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_row(input logic [13:0] row, input int idle, input int cnt_before);
        int   guard;
        logic acc;
        for (int i = 0; i < idle; i++) begin
            in_valid = 1'b0;
            tick();
            check("idle_rows", rows_filled, cnt_before);
            check("idle_out_valid", out_valid, 0);
        end
        in_valid = 1'b1;
        in_row   = row;
        guard    = 0;
        do begin
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 100);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic fill(input int idle, input int start);
        for (int r = start; r < 14; r++) begin
            send_row(img[r], idle, r);
            check("rows_filled", rows_filled, r + 1);
            check("out_valid", out_valid, (r == 13));
            check("in_ready", in_ready, (r != 13));
        end
        in_valid = 1'b0;
    endtask

    task automatic consume(input int hold);
        consume_done = 1'b1;
        repeat (hold) tick();
        consume_done = 1'b0;
        check("clr_out_valid", out_valid, 0);
        check("clr_data", data_out, 0);
        check("clr_rows", rows_filled, 0);
        check("clr_in_ready", in_ready, 1);
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check("rst_rows", rows_filled, 0);
        check("rst_data", data_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b1;

        // All ones, in_valid held high: one accept per edge, full after edge 14.
        for (int r = 0; r < 14; r++) img[r] = 14'h3FFF;
        exp_q.push_back('1);
        fill(0, 0);
        consume(1);

        // Diagonal: bit r*14+r set, identical in either ordering.
        for (int r = 0; r < 14; r++) img[r] = 14'h0001 << r;
        exp_v = '0;
        for (int r = 0; r < 14; r++) exp_v[r * 15] = 1'b1;
        exp_q.push_back(exp_v);
        fill(0, 0);
        consume(3);
        tick();
        check("consume_held_rows", rows_filled, 0);

        // Row 0 column 0 only: bit 0.
        for (int r = 0; r < 14; r++) img[r] = '0;
        img[0] = 14'h0001;
        exp_v = '0;
        exp_v[0] = 1'b1;
        exp_q.push_back(exp_v);
        fill(0, 0);
        consume(1);

        // Row 1 column 0 only: bit 14 row-major, bit 1 column-major.
        img[0] = '0;
        img[1] = 14'h0001;
        exp_v = '0;
`ifdef FLATTEN_COL_MAJOR_EN
        exp_v[1] = 1'b1;
`else
        exp_v[14] = 1'b1;
`endif
        exp_q.push_back(exp_v);
        fill(0, 0);
        consume(1);

        // Three idle cycles before every row.
        for (int r = 0; r < 14; r++) img[r] = 14'((r * 14'h0123) ^ 14'h02A5);
        exp_v = build(14);
        exp_q.push_back(exp_v);
        fill(3, 0);

        // Upstream presents a row while FULL; it must wait and not disturb data.
        in_valid = 1'b1;
        in_row   = 14'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("full_data", data_out, exp_v);
            check("full_rows", rows_filled, 14);
            check("full_in_ready", in_ready, 0);
        end
        img[0] = 14'h1234;
        for (int r = 1; r < 14; r++) img[r] = 14'h0F0F >> (r % 5);
        exp_q.push_back(build(14));
        consume_done = 1'b1;
        tick();
        consume_done = 1'b0;
        check("drain_out_valid", out_valid, 0);
        check("drain_data", data_out, 0);
        check("drain_rows", rows_filled, 0);
        tick();
        check("held_row_rows", rows_filled, 1);
        check("held_row_data", data_out, build(1));
        fill(0, 1);
        consume(1);

        // Reset after 7 rows, with consume_done in FILL ignored first.
        for (int r = 0; r < 14; r++) img[r] = 14'(14'h3A5C >> r) | 14'(r);
        for (int r = 0; r < 7; r++) send_row(img[r], 0, r);
        in_valid = 1'b0;
        check("partial_rows", rows_filled, 7);
        check("partial_data", data_out, build(7));
        consume_done = 1'b1;
        tick();
        consume_done = 1'b0;
        check("fill_ignore_consume", rows_filled, 7);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_rows", rows_filled, 0);
        check("midrst_data", data_out, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.push_back(build(14));
        fill(0, 0);
        tick();
        consume(1);
        tick();
        tick();
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
